// File: rtl/sp_deserializer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sp_deserializer: MSB-first serial-to-parallel word assembler      |
// | that follows the sync detector, with a VALID/READY output holding |
// | register, per-frame word count and a sticky overrun flag.         |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module sp_deserializer #(
  parameter int WIDTH       = 8,
  parameter int FRAME_WORDS = 4,
  parameter int CNT_W       = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             S_IN,
  input  logic             CONVERTION,
  input  logic             READY,
  input  logic             CLR_ERR,
  output logic [WIDTH-1:0] P_OUT,
  output logic             VALID,
  output logic             DONE,
  output logic             OVERRUN,
  output logic [CNT_W-1:0] WORD_CNT,
  output logic             BUSY
);

  localparam int               BIT_W         = $clog2(WIDTH);
  localparam logic [BIT_W-1:0] BIT_LAST      = BIT_W'(WIDTH - 1);
  localparam bit               FRAME_LIMITED = (FRAME_WORDS != 0);
  localparam logic [CNT_W-1:0] FRAME_LAST    = CNT_W'(FRAME_WORDS);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  // Only WIDTH-1 bits are stored; the final bit of a word comes straight from S_IN.
  logic [WIDTH-2:0]   shreg_q, shreg_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]   p_out_q, p_out_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic               overrun_q, overrun_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [WIDTH-1:0]   word_next;
  logic [CNT_W-1:0]   word_cnt_inc;

  assign word_next    = {shreg_q, S_IN};
  assign word_cnt_inc = word_cnt_q + CNT_W'(1);

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    p_out_d    = p_out_q;
    valid_d    = valid_q;
    done_d     = 1'b0;
    overrun_d  = overrun_q;
    word_cnt_d = word_cnt_q;

    if (CLR_ERR) begin
      overrun_d = 1'b0;
    end
    if (valid_q && READY) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        if (CONVERTION) begin
          state_d    = SHIFT;
          word_cnt_d = '0;
        end
      end
      SHIFT: begin
        if (!CONVERTION) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
        end else begin
          shreg_d = word_next[WIDTH-2:0];
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d  = '0;
            word_cnt_d = word_cnt_inc;
            // A held, unconsumed word wins over the new one; drop sets the flag after any clear.
            if (!valid_q || READY) begin
              p_out_d = word_next;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
            if (FRAME_LIMITED && (word_cnt_inc == FRAME_LAST)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      p_out_q    <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      p_out_q    <= p_out_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign P_OUT    = p_out_q;
  assign VALID    = valid_q;
  assign DONE     = done_q;
  assign OVERRUN  = overrun_q;
  assign WORD_CNT = word_cnt_q;
  assign BUSY     = (state_q == SHIFT);

endmodule
`default_nettype wire

// File: tb/tb_sp_deserializer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_sp_deserializer: vector table plus scoreboard bench for        |
// | sp_deserializer (WIDTH=8, FRAME_WORDS=2).                          |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_sp_deserializer;

  localparam int WIDTH       = 8;
  localparam int FRAME_WORDS = 2;
  localparam int CNT_W       = 8;

  logic             CLK = 1'b0;
  logic             RESET;
  logic             S_IN;
  logic             CONVERTION;
  logic             READY;
  logic             CLR_ERR;
  logic [WIDTH-1:0] P_OUT;
  logic             VALID;
  logic             DONE;
  logic             OVERRUN;
  logic [CNT_W-1:0] WORD_CNT;
  logic             BUSY;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] exp_q[$];
  bit               mon_en    = 1'b0;
  int               done_seen = 0;

  typedef struct {
    logic [WIDTH-1:0] w0;
    logic [WIDTH-1:0] w1;
  } vec_t;

  vec_t vecs[4];

  sp_deserializer #(
    .WIDTH      (WIDTH),
    .FRAME_WORDS(FRAME_WORDS),
    .CNT_W      (CNT_W)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .S_IN      (S_IN),
    .CONVERTION(CONVERTION),
    .READY     (READY),
    .CLR_ERR   (CLR_ERR),
    .P_OUT     (P_OUT),
    .VALID     (VALID),
    .DONE      (DONE),
    .OVERRUN   (OVERRUN),
    .WORD_CNT  (WORD_CNT),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock: inputs change on the falling edge, outputs are read 1ns after the rising edge.
  task automatic step(input logic conv, input logic sin, input logic rdy, input logic clr);
    @(negedge CLK);
    CONVERTION = conv;
    S_IN       = sin;
    READY      = rdy;
    CLR_ERR    = clr;
    @(posedge CLK);
    #1;
  endtask

  // Sync edge: CONVERTION high in IDLE; the S_IN value here must be ignored.
  task automatic start_frame(input logic rdy);
    step(1'b1, 1'($urandom_range(0, 1)), rdy, 1'b0);
  endtask

  task automatic send_bits(input logic [WIDTH-1:0] w, input int nbits, input logic rdy);
    for (int i = WIDTH - 1; i >= WIDTH - nbits; i--) begin
      step(1'b1, w[i], rdy, 1'b0);
    end
  endtask

  // Scoreboard monitor: a word is loaded when VALID is high after an edge at which
  // the register was empty or being consumed.
  always @(posedge CLK) begin : monitor
    logic pv;
    logic pr;
    pv = VALID;
    pr = READY;
    #1;
    if (mon_en && RESET) begin
      if (DONE) done_seen++;
      if (VALID && (!pv || pr)) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected_word actual=%0h required=none", P_OUT);
        end else begin
          check("sb_word", P_OUT, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    vecs[0] = '{w0: 8'hA5, w1: 8'hC3};
    vecs[1] = '{w0: 8'h00, w1: 8'hFF};
    vecs[2] = '{w0: 8'h81, w1: 8'h7E};
    vecs[3] = '{w0: 8'h5A, w1: 8'h96};

    RESET      = 1'b0;
    S_IN       = 1'b0;
    CONVERTION = 1'b0;
    READY      = 1'b0;
    CLR_ERR    = 1'b0;
    #1;
    check("reset_valid", VALID, 0);
    check("reset_busy", BUSY, 0);
    check("reset_pout", P_OUT, 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b1;

    // Complete frames with READY held high, words tracked by the scoreboard.
    mon_en = 1'b1;
    for (int v = 0; v < 4; v++) begin
      start_frame(1'b1);
      check("frame_busy", BUSY, 1);
      check("frame_cnt0", WORD_CNT, 0);
      exp_q.push_back(vecs[v].w0);
      send_bits(vecs[v].w0, WIDTH, 1'b1);
      check("w0_valid", VALID, 1);
      check("w0_cnt", WORD_CNT, 1);
      check("w0_done", DONE, 0);
      exp_q.push_back(vecs[v].w1);
      send_bits(vecs[v].w1, WIDTH, 1'b1);
      check("w1_done", DONE, 1);
      check("w1_cnt", WORD_CNT, 2);
      check("w1_busy", BUSY, 0);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      check("post_done", DONE, 0);
      check("post_valid", VALID, 0);
      check("post_pout", P_OUT, vecs[v].w1);
    end
    mon_en = 1'b0;
    check("sb_empty", exp_q.size(), 0);
    check("done_count", done_seen, 4);

    // Downstream stalled: second word dropped, first held.
    start_frame(1'b0);
    send_bits(8'h3C, WIDTH, 1'b0);
    check("stall_w0", P_OUT, 8'h3C);
    check("stall_ovr0", OVERRUN, 0);
    send_bits(8'hFF, WIDTH, 1'b0);
    check("stall_hold", P_OUT, 8'h3C);
    check("stall_valid", VALID, 1);
    check("stall_ovr", OVERRUN, 1);
    check("stall_cnt", WORD_CNT, 2);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("drain_valid", VALID, 0);
    check("drain_pout", P_OUT, 8'h3C);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("clr_ovr", OVERRUN, 0);

    // READY arrives on the very edge the next word completes.
    start_frame(1'b0);
    send_bits(8'h11, WIDTH, 1'b0);
    send_bits(8'h22, WIDTH - 1, 1'b0);
    check("edge_hold", P_OUT, 8'h11);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check("edge_pout", P_OUT, 8'h22);
    check("edge_valid", VALID, 1);
    check("edge_ovr", OVERRUN, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("edge_drain", VALID, 0);

    // Abort after 5 bits, then resync with a full word.
    start_frame(1'b1);
    send_bits(8'hFF, 5, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("abort_busy", BUSY, 0);
    check("abort_valid", VALID, 0);
    check("abort_done", DONE, 0);
    start_frame(1'b1);
    send_bits(8'h5A, WIDTH, 1'b1);
    check("resync_pout", P_OUT, 8'h5A);
    check("resync_valid", VALID, 1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("abort_cnt_hold", WORD_CNT, 1);
    check("abort_done2", DONE, 0);

    // Back-to-back frames: CONVERTION never drops across the DONE edge.
    start_frame(1'b1);
    send_bits(8'hF0, WIDTH, 1'b1);
    send_bits(8'h0F, WIDTH, 1'b1);
    check("b2b_done", DONE, 1);
    start_frame(1'b1);
    check("b2b_busy", BUSY, 1);
    check("b2b_cnt", WORD_CNT, 0);
    send_bits(8'hC6, WIDTH, 1'b1);
    check("b2b_pout", P_OUT, 8'hC6);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Clear and drop on the same edge: set wins.
    start_frame(1'b0);
    send_bits(8'h01, WIDTH, 1'b0);
    send_bits(8'h02, WIDTH - 1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("setwins_ovr", OVERRUN, 1);
    check("setwins_pout", P_OUT, 8'h01);

    // Asynchronous reset mid-SHIFT with VALID and OVERRUN set.
    start_frame(1'b0);
    send_bits(8'hAA, 3, 1'b0);
    check("pre_rst_busy", BUSY, 1);
    check("pre_rst_valid", VALID, 1);
    @(negedge CLK);
    #2;
    RESET = 1'b0;
    #1;
    check("arst_valid", VALID, 0);
    check("arst_ovr", OVERRUN, 0);
    check("arst_busy", BUSY, 0);
    check("arst_pout", P_OUT, 0);
    @(negedge CLK);
    RESET = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'(i & 1), 1'b0, 1'b0);
    end
    check("idle_valid", VALID, 0);
    check("idle_busy", BUSY, 0);
    check("idle_cnt", WORD_CNT, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
